// File: rtl/alu_pkg.sv
// Shared constants for the ALU, its op decoder and the issue controller.
// Op codes follow the classic MIPS ALU-control encoding.
package alu_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   localparam logic [1:0] ALUOP_MEM   = 2'b00;
   localparam logic [1:0] ALUOP_BEQ   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_NOR = 6'b100111;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StIssue = 2'b01,
      StResp  = 2'b10
   } state_e;

endpackage

// File: rtl/alu.sv
// Combinational MIPS-style ALU: AND, OR, ADD, SUB, signed SLT, NOR.
module alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic [WIDTH-1:0] result
);

   always_comb begin
      result = '0;
      case (op)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_NOR:  result = ~(a | b);
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_op_decode.sv
// Maps main-decode ALUOp plus R-type funct onto a 4-bit ALU op code.
// Unknown encodings yield OP_AND with illegal raised.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [3:0] op,
   output logic       illegal
);

   always_comb begin
      op      = OP_AND;
      illegal = 1'b0;
      case (aluop)
         ALUOP_MEM: op = OP_ADD;
         ALUOP_BEQ: op = OP_SUB;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD: op = OP_ADD;
               FUNCT_SUB: op = OP_SUB;
               FUNCT_AND: op = OP_AND;
               FUNCT_OR:  op = OP_OR;
               FUNCT_NOR: op = OP_NOR;
               FUNCT_SLT: op = OP_SLT;
               default:   illegal = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequential front end for the combinational ALU: accepts a command, drives the
// ALU for one cycle, then returns the captured result on a valid/ready channel.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [1:0]       cmd_aluop,
   input  logic [5:0]       cmd_funct,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_illegal
);

   state_e           state_q;
   logic [WIDTH-1:0] alu_a_q, alu_b_q, rsp_result_q;
   logic [3:0]       alu_op_q;
   logic             illegal_q, rsp_valid_q, rsp_zero_q, rsp_illegal_q;

   logic [3:0]       dec_op;
   logic             dec_illegal;

   alu_op_decode u_decode (
      .aluop   (cmd_aluop),
      .funct   (cmd_funct),
      .op      (dec_op),
      .illegal (dec_illegal)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_op_q      <= '0;
         illegal_q     <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_result_q  <= '0;
         rsp_zero_q    <= 1'b0;
         rsp_illegal_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  alu_a_q   <= cmd_a;
                  alu_b_q   <= cmd_b;
                  alu_op_q  <= dec_op;
                  illegal_q <= dec_illegal;
                  state_q   <= StIssue;
               end
            end
            StIssue: begin
               rsp_result_q  <= alu_result;
               rsp_zero_q    <= (alu_result == '0);
               rsp_illegal_q <= illegal_q;
               rsp_valid_q   <= 1'b1;
               state_q       <= StResp;
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Held low while rst is asserted so no command is accepted during reset.
   assign cmd_ready   = (state_q == StIdle) && !rst;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_result  = rsp_result_q;
   assign rsp_zero    = rsp_zero_q;
   assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl driving the real ALU with directed vectors.
module tb_alu_issue_ctrl;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_valid = 1'b0;
   logic         rsp_ready = 1'b1;
   logic [W-1:0] cmd_a = '0;
   logic [W-1:0] cmd_b = '0;
   logic [1:0]   cmd_aluop = '0;
   logic [5:0]   cmd_funct = '0;
   logic         cmd_ready, rsp_valid, rsp_zero, rsp_illegal;
   logic [W-1:0] alu_a, alu_b, alu_result, rsp_result;
   logic [3:0]   alu_op;

   alu_issue_ctrl #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .cmd_aluop   (cmd_aluop),
      .cmd_funct   (cmd_funct),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_op      (alu_op),
      .alu_result  (alu_result),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_zero    (rsp_zero),
      .rsp_illegal (rsp_illegal)
   );

   alu #(.WIDTH(W)) u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .op     (alu_op),
      .result (alu_result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [W-1:0] result;
      logic         zero;
      logic         ill;
      int           acc;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares every presented response against the scoreboard head;
   // pops only on handshake, so a stalled response is re-checked each cycle.
   logic prev_v = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prev_v = 1'b0;
      end else begin
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL spurious_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
            end else begin
               // rsp_valid must appear after the edge that ends the ISSUE cycle
               if (!prev_v) check("latency", 32'(cyc - sb[0].acc), 32'd1);
               check("rsp_result", 32'(rsp_result), 32'(sb[0].result));
               check("rsp_zero", 32'(rsp_zero), 32'(sb[0].zero));
               check("rsp_illegal", 32'(rsp_illegal), 32'(sb[0].ill));
               check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
               if (rsp_ready) void'(sb.pop_front());
            end
         end
         prev_v = rsp_valid;
      end
   end

   task automatic wait_ready();
      int t = 0;
      @(negedge clk);
      while (!cmd_ready && t < 30) begin
         @(negedge clk);
         t++;
      end
      check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
   endtask

   task automatic send(input logic [1:0] aluop, input logic [5:0] funct,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] eop, input logic [W-1:0] eres,
                       input logic eill, input bit wait_done);
      exp_t e;
      wait_ready();
      cmd_valid = 1'b1;
      cmd_aluop = aluop;
      cmd_funct = funct;
      cmd_a     = a;
      cmd_b     = b;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      e.result  = eres;
      e.zero    = (eres == '0);
      e.ill     = eill;
      e.acc     = cyc;
      sb.push_back(e);
      @(negedge clk);
      check("issue_alu_op", 32'(alu_op), 32'(eop));
      check("issue_alu_a", 32'(alu_a), 32'(a));
      check("issue_alu_b", 32'(alu_b), 32'(b));
      if (wait_done) wait_ready();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int t;
      repeat (3) @(posedge clk);
      #1;
      check("rst_alu_a", 32'(alu_a), 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_result", 32'(rsp_result), 32'd0);
      check("rst_rsp_flags", 32'({rsp_zero, rsp_illegal}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

      //    aluop  funct      a      b      op       result  ill
      send(2'b10, 6'b100000, 4'd6, 4'd2, 4'b0010, 4'd8,  1'b0, 1'b1);
      send(2'b10, 6'b100000, 4'd9, 4'd9, 4'b0010, 4'd2,  1'b0, 1'b1);
      send(2'b01, 6'b000000, 4'd6, 4'd6, 4'b0110, 4'd0,  1'b0, 1'b1);
      send(2'b00, 6'b000000, 4'd6, 4'd2, 4'b0010, 4'd8,  1'b0, 1'b1);
      send(2'b10, 6'b100100, 4'd6, 4'd2, 4'b0000, 4'd2,  1'b0, 1'b1);
      send(2'b10, 6'b100101, 4'd6, 4'd2, 4'b0001, 4'd6,  1'b0, 1'b1);
      send(2'b10, 6'b101010, 4'd6, 4'd2, 4'b0111, 4'd0,  1'b0, 1'b1);
      send(2'b10, 6'b101010, 4'd2, 4'd6, 4'b0111, 4'd1,  1'b0, 1'b1);
      send(2'b10, 6'b100111, 4'd6, 4'd2, 4'b1100, 4'd9,  1'b0, 1'b1);
      send(2'b10, 6'b100010, 4'd6, 4'd2, 4'b0110, 4'd4,  1'b0, 1'b1);
      send(2'b10, 6'b111111, 4'd6, 4'd2, 4'b0000, 4'd2,  1'b1, 1'b1);
      send(2'b11, 6'b100000, 4'd6, 4'd2, 4'b0000, 4'd2,  1'b1, 1'b1);

      // Backpressure: 5 - 7 wraps to 14; a stray command mid-stall is dropped.
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      send(2'b10, 6'b100010, 4'd5, 4'd7, 4'b0110, 4'd14, 1'b0, 1'b0);
      t = 0;
      while (!rsp_valid && t < 10) begin
         @(negedge clk);
         t++;
      end
      check("bp_valid_timeout", 32'(rsp_valid), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_aluop = 2'b00;
      cmd_a     = 4'd1;
      cmd_b     = 4'd1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_idle_ready", 32'(cmd_ready), 32'd1);
      check("bp_idle_valid", 32'(rsp_valid), 32'd0);
      check("bp_ignored_a", 32'(alu_a), 32'd5);
      check("bp_ignored_op", 32'(alu_op), 32'(4'b0110));

      // Reset during ISSUE discards the in-flight command.
      wait_ready();
      cmd_valid = 1'b1;
      cmd_aluop = 2'b10;
      cmd_funct = 6'b100101;
      cmd_a     = 4'd3;
      cmd_b     = 4'd12;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      rst       = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_alu_a", 32'(alu_a), 32'd0);
      check("midrst_alu_b", 32'(alu_b), 32'd0);
      check("midrst_alu_op", 32'(alu_op), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
      repeat (2) @(negedge clk);
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);

      send(2'b00, 6'b000000, 4'd3, 4'd4, 4'b0010, 4'd7, 1'b0, 1'b1);

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
